nbody_pair_force_pe: RTL

- Pairwise force processing element. Accepts (body i, body j) position pairs and computes the squared distance r2.
- Encodes r2 into the {idx, frac} request code consumed by the piecewise-linear LUT interpolator, and issues one LUT request per pair.
- Consumes the returned Q4.12 kernel value g and accumulates g·dx, g·dy, g·dz into per-body force accumulators.
- Emits the total force for body i after the pair flagged last.

---
 rtl/nbody_pkg.sv | 35 +++
 rtl/nbody_pair_force_pe_if.sv | 36 +++
 rtl/nbody_r2_encoder.sv | 33 +++
 rtl/nbody_pair_force_pe.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/nbody_pkg.sv
// Shared definitions for the pairwise N-body force processing element:
// default widths, FSM state encoding and the saturating accumulator add.
package nbody_pkg;

    localparam int NB_POS_W  = 16;  // signed Q8.8 position width
    localparam int NB_FRAC_Q = 8;   // fractional bits of a position
    localparam int NB_G_FRAC = 12;  // fractional bits of the Q4.12 kernel value
    localparam int NB_ACC_W  = 32;  // force accumulator width

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        REQ  = 3'd2,
        WAIT = 3'd3,
        ACC  = 3'd4,
        OUT  = 3'd5
    } pe_state_t;

    // Signed add that clamps to the most positive / most negative value
    // instead of wrapping.
    function automatic logic signed [NB_ACC_W-1:0] sat_add(
        input logic signed [NB_ACC_W-1:0] a,
        input logic signed [NB_ACC_W-1:0] b
    );
        logic signed [NB_ACC_W:0] s;
        s = {a[NB_ACC_W-1], a} + {b[NB_ACC_W-1], b};
        if (s[NB_ACC_W] != s[NB_ACC_W-1]) begin
            sat_add = s[NB_ACC_W] ? {1'b1, {(NB_ACC_W-1){1'b0}}}
                                  : {1'b0, {(NB_ACC_W-1){1'b1}}};
        end else begin
            sat_add = s[NB_ACC_W-1:0];
        end
    endfunction

endpackage

// File: rtl/nbody_pair_force_pe_if.sv
// Pair input stream, LUT request/response and force result bundle of the
// pairwise force PE. The slave modport is the PE side.
interface nbody_pair_force_pe_if #(
    parameter int POS_W = 16,
    parameter int ACC_W = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [POS_W-1:0] pi_x, pi_y, pi_z;
    logic signed [POS_W-1:0] pj_x, pj_y, pj_z;
    logic                    last_j;

    logic                    lut_req_valid;
    logic [15:0]             lut_r2_code;
    logic signed [15:0]      lut_g;
    logic                    lut_ready;

    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] f_x, f_y, f_z;
    logic                    err_timeout;

    modport master (
        output in_valid, pi_x, pi_y, pi_z, pj_x, pj_y, pj_z, last_j,
        output lut_g, lut_ready, out_ready,
        input  in_ready, lut_req_valid, lut_r2_code,
        input  out_valid, f_x, f_y, f_z, err_timeout
    );

    modport slave (
        input  in_valid, pi_x, pi_y, pi_z, pj_x, pj_y, pj_z, last_j,
        input  lut_g, lut_ready, out_ready,
        output in_ready, lut_req_valid, lut_r2_code,
        output out_valid, f_x, f_y, f_z, err_timeout
    );
endinterface

// File: rtl/nbody_r2_encoder.sv
// Combinational squared-distance encoder: dx/dy/dz -> Q16.16 r2, scaled
// down by R2_SHIFT, softened by EPS2 and clamped to a 16-bit LUT code.
module nbody_r2_encoder
    import nbody_pkg::*;
#(
    parameter int          POS_W    = NB_POS_W,
    parameter int          R2_SHIFT = 8,
    parameter logic [15:0] EPS2     = 16'h0010
) (
    input  logic signed [POS_W:0] i_dx,
    input  logic signed [POS_W:0] i_dy,
    input  logic signed [POS_W:0] i_dz,
    output logic [15:0]           o_code
);
    localparam int SQ_W = 2 * (POS_W + 1);
    localparam int R2_W = SQ_W + 2;

    // Squares are never negative, so zero-extending them into r2 is exact.
    logic signed [SQ_W-1:0] w_sq_x, w_sq_y, w_sq_z;
    logic [R2_W-1:0]        w_r2;
    logic [R2_W-1:0]        w_s;

    assign w_sq_x = i_dx * i_dx;
    assign w_sq_y = i_dy * i_dy;
    assign w_sq_z = i_dz * i_dz;

    assign w_r2 = R2_W'($unsigned(w_sq_x)) + R2_W'($unsigned(w_sq_y))
                + R2_W'($unsigned(w_sq_z));
    assign w_s  = (w_r2 >> R2_SHIFT) + R2_W'(EPS2);

    // Anything beyond the LUT's 16-bit range maps to the last entry.
    assign o_code = (|w_s[R2_W-1:16]) ? 16'hFFFF : w_s[15:0];
endmodule

// File: rtl/nbody_pair_force_pe.sv
// Pairwise force processing element: takes (body i, body j) pairs, issues
// one LUT request per pair with the encoded r2, scales dx/dy/dz by the
// returned kernel value and accumulates the force on body i until the pair
// flagged last, then presents the total and waits for it to be taken.
module nbody_pair_force_pe
    import nbody_pkg::*;
#(
    parameter int          POS_W       = NB_POS_W,
    parameter int          ACC_W       = NB_ACC_W,
    parameter int          R2_SHIFT    = 8,
    parameter logic [15:0] EPS2        = 16'h0010,
    parameter int          LUT_TIMEOUT = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    nbody_pair_force_pe_if.slave pe
);
    localparam int CNT_W  = $clog2(LUT_TIMEOUT + 1);
    localparam int PROD_W = POS_W + 1 + 16;

    pe_state_t r_state, w_next;

    logic signed [POS_W:0]   r_dx, r_dy, r_dz;
    logic signed [15:0]      r_g;
    logic                    r_last;
    logic [15:0]             r_code;
    logic [CNT_W-1:0]        r_wait_cnt;
    logic                    r_err;
    logic signed [ACC_W-1:0] r_acc_x, r_acc_y, r_acc_z;

    logic signed [POS_W:0]   w_dx_in, w_dy_in, w_dz_in;
    logic [15:0]             w_code;
    logic                    w_accept;
    logic                    w_timeout;
    logic                    w_in_ready, w_req_valid, w_out_valid;
    logic signed [PROD_W-1:0] w_px, w_py, w_pz;
    logic signed [ACC_W-1:0]  w_tx, w_ty, w_tz;

    // One extra bit keeps pj - pi exact over the full Q8.8 range.
    assign w_dx_in = {pe.pj_x[POS_W-1], pe.pj_x} - {pe.pi_x[POS_W-1], pe.pi_x};
    assign w_dy_in = {pe.pj_y[POS_W-1], pe.pj_y} - {pe.pi_y[POS_W-1], pe.pi_y};
    assign w_dz_in = {pe.pj_z[POS_W-1], pe.pj_z} - {pe.pi_z[POS_W-1], pe.pi_z};

    assign w_accept  = (r_state == IDLE) && pe.in_valid;
    assign w_timeout = (r_state == WAIT) && !pe.lut_ready
                    && (r_wait_cnt == CNT_W'(LUT_TIMEOUT - 1));

    nbody_r2_encoder #(
        .POS_W    (POS_W),
        .R2_SHIFT (R2_SHIFT),
        .EPS2     (EPS2)
    ) u_r2_enc (
        .i_dx   (r_dx),
        .i_dy   (r_dy),
        .i_dz   (r_dz),
        .o_code (w_code)
    );

    // g (Q4.12) times d (Q8.8) gives Q.20; dropping 12 bits leaves Q.8.
    assign w_px = r_g * r_dx;
    assign w_py = r_g * r_dy;
    assign w_pz = r_g * r_dz;
    assign w_tx = ACC_W'(w_px >>> NB_G_FRAC);
    assign w_ty = ACC_W'(w_py >>> NB_G_FRAC);
    assign w_tz = ACC_W'(w_pz >>> NB_G_FRAC);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_req_valid = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (pe.in_valid) w_next = CALC;
            end
            CALC: w_next = REQ;
            REQ: begin
                w_req_valid = 1'b1;
                w_next      = WAIT;
            end
            WAIT: if (pe.lut_ready || w_timeout) w_next = ACC;
            ACC:  w_next = r_last ? OUT : IDLE;
            OUT: begin
                w_out_valid = 1'b1;
                if (pe.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Control, LUT code, error flag and force accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= 1'b0;
            r_code     <= '0;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
            r_acc_x    <= '0;
            r_acc_y    <= '0;
            r_acc_z    <= '0;
        end else begin
            if (w_accept) r_last <= pe.last_j;
            if (r_state == CALC) r_code <= w_code;
            r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + 1'b1 : '0;
            if (w_timeout) r_err <= 1'b1;
            if (r_state == ACC) begin
                r_acc_x <= sat_add(r_acc_x, w_tx);
                r_acc_y <= sat_add(r_acc_y, w_ty);
                r_acc_z <= sat_add(r_acc_z, w_tz);
            end else if ((r_state == OUT) && pe.out_ready) begin
                r_acc_x <= '0;
                r_acc_y <= '0;
                r_acc_z <= '0;
            end
        end
    end

    // Per-pair operands; a missed LUT response contributes g = 0.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_dx <= w_dx_in;
            r_dy <= w_dy_in;
            r_dz <= w_dz_in;
        end
        if (r_state == WAIT) begin
            if (pe.lut_ready) r_g <= pe.lut_g;
            else if (w_timeout) r_g <= '0;
        end
    end

    assign pe.in_ready      = rst_n && w_in_ready;
    assign pe.lut_req_valid = w_req_valid;
    assign pe.lut_r2_code   = r_code;
    assign pe.out_valid     = w_out_valid;
    assign pe.f_x           = r_acc_x;
    assign pe.f_y           = r_acc_y;
    assign pe.f_z           = r_acc_z;
    assign pe.err_timeout   = r_err;
endmodule
